// File: rtl/math_multiplier_seq_016_ctrl_pkg.sv
// Shared types and constants for the sequenced 16x16 multiplier.
// Holds the FSM state enum and the per-pass operand/shift selection.
package math_mul_seq_pkg;

    localparam int N = 16;
    localparam int H = 8;
    localparam int P = 2 * N;

    localparam logic [1:0] LAST_PASS = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic       a_hi;
        logic       b_hi;
        logic [4:0] shift;
    } pass_t;

    localparam pass_t PASS0 = '{a_hi: 1'b0, b_hi: 1'b0, shift: 5'd0};
    localparam pass_t PASS1 = '{a_hi: 1'b0, b_hi: 1'b1, shift: 5'd8};
    localparam pass_t PASS2 = '{a_hi: 1'b1, b_hi: 1'b0, shift: 5'd8};
    localparam pass_t PASS3 = '{a_hi: 1'b1, b_hi: 1'b1, shift: 5'd16};

    function automatic pass_t pass_sel(input logic [1:0] cnt);
        pass_t r;
        unique case (cnt)
            2'd0: r = PASS0;
            2'd1: r = PASS1;
            2'd2: r = PASS2;
            default: r = PASS3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/math_multiplier_seq_016_ctrl_if.sv
// Request/response bundle for the sequenced multiplier.
// master = requester/consumer side, slave = multiplier side.
interface math_multiplier_seq_016_ctrl_if;
    import math_mul_seq_pkg::*;

    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_multiplier;
    logic [N-1:0] i_multiplicand;
    logic         o_valid;
    logic         i_ready;
    logic [P-1:0] o_product;
    logic         o_busy;

    modport master (
        output i_valid,
        output i_multiplier,
        output i_multiplicand,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_product,
        input  o_busy
    );

    modport slave (
        input  i_valid,
        input  i_multiplier,
        input  i_multiplicand,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_product,
        output o_busy
    );

endinterface

// File: rtl/math_multiplier_seq_016_ctrl_wallace.sv
// Combinational 8x8 unsigned multiplier, Wallace tree of 3:2 CSAs.
// Eight partial-product rows reduce 8->6->4->3->2, then one final add.
module math_multiplier_wallace_tree_csa_008 #(
    parameter int N = 8
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_p
);

    localparam int W = 2 * N;

    logic [W-1:0] pp [8];
    logic [W-1:0] s0, c0, s1, c1, s2, c2;
    logic [W-1:0] s3, c3, s4, c4, s5, c5;

    function automatic logic [2*W-1:0] csa3(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic [W-1:0] z
    );
        logic [W-1:0] s;
        logic [W-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    // Partial-product generation and carry-save reduction tree
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = i_b[i] ? (W'(i_a) << i) : '0;
        end
        {c0, s0} = csa3(pp[0], pp[1], pp[2]);
        {c1, s1} = csa3(pp[3], pp[4], pp[5]);
        {c2, s2} = csa3(s0, c0, s1);
        {c3, s3} = csa3(c1, pp[6], pp[7]);
        {c4, s4} = csa3(s2, c2, s3);
        {c5, s5} = csa3(s4, c4, c3);
        o_p      = s5 + c5;
    end

endmodule

// File: rtl/math_multiplier_seq_016_ctrl.sv
// 16x16 unsigned multiplier built from four passes of a shared 8x8 core.
// Each MUL cycle selects an operand-half pair and shift-accumulates.
module math_multiplier_seq_016_ctrl
    import math_mul_seq_pkg::*;
(
    input  logic                            i_clk,
    input  logic                            i_rst,
    math_multiplier_seq_016_ctrl_if.slave   bus
);

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [P-1:0] acc_q, acc_d;
    logic [P-1:0] prod_q, prod_d;

    pass_t        sel;
    logic [H-1:0] core_a;
    logic [H-1:0] core_b;
    logic [2*H-1:0] core_p;
    logic [P-1:0] pp_sh;
    logic [P-1:0] acc_sum;

    assign sel    = pass_sel(cnt_q);
    assign core_a = sel.a_hi ? a_q[N-1:H] : a_q[H-1:0];
    assign core_b = sel.b_hi ? b_q[N-1:H] : b_q[H-1:0];

    math_multiplier_wallace_tree_csa_008 #(
        .N (H)
    ) u_core (
        .i_a (core_a),
        .i_b (core_b),
        .o_p (core_p)
    );

    assign pp_sh   = P'(core_p) << sel.shift;
    assign acc_sum = acc_q + pp_sh;

    // State, pass counter, operands and accumulator registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state: accept in IDLE, four accumulate passes, hold in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_multiplier;
                    b_d     = bus.i_multiplicand;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_PASS) begin
                    prod_d  = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode straight from state so reset acts at once
    assign bus.o_ready   = (state_q == IDLE);
    assign bus.o_valid   = (state_q == DONE);
    assign bus.o_busy    = (state_q != IDLE);
    assign bus.o_product = prod_q;

endmodule

// File: tb/tb_math_multiplier_seq_016_ctrl.sv
// Scoreboard bench for the sequenced 16x16 multiplier.
// Expected products queued at accept, compared at output handshake.
module tb_math_multiplier_seq_016_ctrl;

    logic clk;
    logic rst;

    math_multiplier_seq_016_ctrl_if ifc ();

    math_multiplier_seq_016_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          cyc;
    logic [31:0] sb [$];

    int          acc_edge;
    int          prev_acc;
    bit          b2b;
    bit          rnd_on;
    logic        prev_v;
    logic        stall_prev;
    logic [31:0] prod_prev;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h at cyc %0d",
                     tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            ifc.i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_v     = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (ifc.i_valid && ifc.o_ready) begin
                sb.push_back({16'h0, ifc.i_multiplier} *
                             {16'h0, ifc.i_multiplicand});
                if (b2b && prev_acc >= 0)
                    chk("ii", 32'(cyc + 1 - prev_acc), 32'd6);
                prev_acc = cyc + 1;
                acc_edge = cyc + 1;
            end
            if (ifc.o_valid && !prev_v)
                chk("lat", 32'(cyc - acc_edge), 32'd4);
            if (stall_prev)
                chk("hold", ifc.o_product, prod_prev);
            if (ifc.o_valid && ifc.i_ready) begin
                if (sb.size() == 0)
                    chk("sb_empty", 32'(sb.size()), 32'd1);
                else
                    chk("prod", ifc.o_product, sb.pop_front());
            end
            prev_v     = ifc.o_valid;
            stall_prev = ifc.o_valid && !ifc.i_ready;
            prod_prev  = ifc.o_product;
        end
    end

    task automatic req(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk);
        #1;
        ifc.i_valid        = 1'b1;
        ifc.i_multiplier   = a;
        ifc.i_multiplicand = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ifc.o_ready) break;
        end
        chk("acc_rdy", 32'(ifc.o_ready), 32'd1);
        @(posedge clk);
        #1;
        ifc.i_valid        = 1'b0;
        ifc.i_multiplier   = 16'($urandom);
        ifc.i_multiplicand = 16'($urandom);
    endtask

    task automatic wait_vld();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ifc.o_valid) break;
        end
        chk("vld", 32'(ifc.o_valid), 32'd1);
    endtask

    function automatic logic [15:0] rnd_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 16'hFFFF;
        if (r == 1) return 16'h0000;
        return 16'($urandom);
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        acc_edge = 0;
        prev_acc = -1;
        b2b = 1'b0;
        rnd_on = 1'b0;
        prev_v = 1'b0;
        stall_prev = 1'b0;
        prod_prev = '0;
        rst = 1'b1;
        ifc.i_valid = 1'b0;
        ifc.i_ready = 1'b0;
        ifc.i_multiplier = '0;
        ifc.i_multiplicand = '0;

        @(negedge clk);
        chk("rst_valid", 32'(ifc.o_valid), 32'd0);
        chk("rst_prod", ifc.o_product, 32'd0);
        chk("rst_busy", 32'(ifc.o_busy), 32'd0);
        chk("rst_ready", 32'(ifc.o_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        ifc.i_ready = 1'b1;
        req(16'h1234, 16'h5678);
        wait_vld();
        chk("p1234", ifc.o_product, 32'h06260060);
        chk("rdy_in_done", 32'(ifc.o_ready), 32'd0);
        @(negedge clk);
        chk("rdy_after", 32'(ifc.o_ready), 32'd1);
        chk("vld_after", 32'(ifc.o_valid), 32'd0);
        chk("prod_keep", ifc.o_product, 32'h06260060);

        req(16'hFFFF, 16'hFFFF);
        wait_vld();
        chk("pmax", ifc.o_product, 32'hFFFE0001);
        @(negedge clk);

        req(16'h0000, 16'hABCD);
        wait_vld();
        chk("pzero", ifc.o_product, 32'h00000000);
        @(negedge clk);

        ifc.i_ready = 1'b0;
        req(16'h0102, 16'h0304);
        wait_vld();
        @(posedge clk);
        #1;
        ifc.i_valid        = 1'b1;
        ifc.i_multiplier   = 16'hAAAA;
        ifc.i_multiplicand = 16'h5555;
        repeat (10) begin
            @(negedge clk);
            chk("bp_vld", 32'(ifc.o_valid), 32'd1);
            chk("bp_prod", ifc.o_product, 32'h00030A08);
            chk("bp_rdy", 32'(ifc.o_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        ifc.i_valid = 1'b0;
        ifc.i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle", 32'(ifc.o_busy), 32'd0);

        req(16'h1111, 16'h2222);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("ar_busy", 32'(ifc.o_busy), 32'd0);
        chk("ar_valid", 32'(ifc.o_valid), 32'd0);
        chk("ar_ready", 32'(ifc.o_ready), 32'd1);
        chk("ar_prod", ifc.o_product, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ar_rdy1", 32'(ifc.o_ready), 32'd1);
        req(16'h00FF, 16'h0100);
        wait_vld();
        chk("p_ff00", ifc.o_product, 32'h0000FF00);
        @(negedge clk);

        prev_acc = -1;
        b2b = 1'b1;
        @(posedge clk);
        #1;
        ifc.i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifc.i_multiplier   = rnd_op();
            ifc.i_multiplicand = rnd_op();
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (ifc.o_ready) break;
            end
            chk("b2b_rdy", 32'(ifc.o_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        ifc.i_valid = 1'b0;
        b2b = 1'b0;
        repeat (8) @(negedge clk);

        rnd_on = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            req(rnd_op(), rnd_op());
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2 ifc.i_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !ifc.o_busy) break;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(ifc.o_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
